mem_arbiter: RTL and testbench

Arbitrates the pipeline's single shared unified memory between the instruction-side cache (fetch miss) and the data-side cache (load miss or store write-through). It sequences multi-word block fills and single-word writes. It sits between the IF/MEM stage caches and the pipelined memory, and drives `busy`, which the hazard unit uses to stall the pipeline.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between I-cache fills and D-cache fills/write-throughs.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined (default: fixed data priority).
module mem_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_req,
    input  logic [15:0]                    i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [15:0]                    d_addr,
    input  logic [15:0]                    d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);
    localparam int              AW       = $clog2(BLOCK_WORDS);
    localparam logic [AW:0]     ISS_END  = (AW+1)'(BLOCK_WORDS);
    localparam logic [AW-1:0]   RET_LAST = AW'(BLOCK_WORDS-1);
    localparam logic [15:0]     OFS_MASK = 16'(2*BLOCK_WORDS-1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;    // 1 = data side owns the current operation
    logic [15:0]   addr_q,  addr_d;     // block base for fills, full address for writes
    logic [15:0]   wdata_q, wdata_d;
    logic [AW:0]   iss_q,   iss_d;
    logic [AW-1:0] ret_q,   ret_d;
    logic          gnt_d_side;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d_q <= 1'b0;
        else if (state_q == IDLE && (i_req || d_req))
            last_d_q <= gnt_d_side;
    end
    // On a tie, the side that did not win last time gets the memory.
    assign gnt_d_side = d_req && (!i_req || !last_d_q);
`else
    assign gnt_d_side = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_d_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            own_d_q <= own_d_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d_d = own_d_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        iss_d   = iss_q;
        ret_d   = ret_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    own_d_d = gnt_d_side;
                    iss_d   = '0;
                    ret_d   = '0;
                    if (gnt_d_side && d_wr) begin
                        state_d = WRITE;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = FILL;
                        addr_d  = (gnt_d_side ? d_addr : i_addr) & ~OFS_MASK;
                    end
                end
            end
            FILL: begin
                if (iss_q != ISS_END)
                    iss_d = iss_q + 1'b1;
                if (mem_valid) begin
                    ret_d = ret_q + 1'b1;
                    if (ret_q == RET_LAST)
                        state_d = DONE;
                end
            end
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == FILL && iss_q != ISS_END) begin
            mem_en   = 1'b1;
            mem_addr = addr_q + (16'(iss_q) << 1);
        end else if (state_q == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign fill_data = mem_rdata;
    assign fill_word = ret_q;
    assign i_fill_we = (state_q == FILL) && mem_valid && !own_d_q;
    assign d_fill_we = (state_q == FILL) && mem_valid &&  own_d_q;
    assign i_done    = (state_q == DONE) && !own_d_q;
    assign d_done    = (state_q == DONE) &&  own_d_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against an operation-timeline model.
module tb_mem_arbiter;
    localparam int BW = 8;
    localparam int L  = 4;
    localparam int AW = $clog2(BW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
    logic          mem_en, mem_wr, mem_valid = 1'b0;
    logic [15:0]   mem_addr, mem_wdata, mem_rdata = '0, fill_data;
    logic [AW-1:0] fill_word;
    logic          i_fill_we, d_fill_we, i_done, d_done, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'h5AC3;
    endfunction

    function automatic int done_r(input bit w);
        return w ? 2 : BW + L + 1;
    endfunction

    // Model: an operation is a timeline of offsets r = 1.. counted from the grant.
    int          cyc = 0;
    bit          m_act = 0, m_wr = 0, m_d = 0, m_last_d = 0;
    int          m_r = 0;
    logic [15:0] m_base = '0, m_waddr = '0, m_wdata = '0;
    bit          m_i_done_prev = 0, m_d_done_prev = 0;
    logic        m_win_d;

`ifdef MEM_ARB_RR_EN
    assign m_win_d = d_req && (!i_req || !m_last_d);
`else
    assign m_win_d = d_req;
`endif

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        m_i_done_prev <= rst_n && m_act && m_r == done_r(m_wr) && !m_d;
        m_d_done_prev <= rst_n && m_act && m_r == done_r(m_wr) &&  m_d;
        if (!rst_n) begin
            m_act    <= 0;
            m_last_d <= 0;
        end else if (m_act) begin
            m_r <= m_r + 1;
            if (m_r == done_r(m_wr)) m_act <= 0;
        end else if (i_req || d_req) begin
            m_act    <= 1;
            m_r      <= 1;
            m_d      <= m_win_d;
            m_wr     <= m_win_d && d_wr;
            m_base   <= (m_win_d ? d_addr : i_addr) & ~16'(2*BW-1);
            m_waddr  <= d_addr;
            m_wdata  <= d_wdata;
            m_last_d <= m_win_d;
        end
    end

    // Fixed-latency memory: a read issued in cycle k returns in cycle k+L.
    bit          allow_stray = 0;
    logic        cap_rd;
    logic [15:0] cap_addr;
    bit          pv [L];
    logic [15:0] pd [L];
    initial begin
        for (int i = 0; i < L; i++) begin pv[i] = 0; pd[i] = '0; end
        forever begin
            @(negedge clk);
            cap_rd   = mem_en && !mem_wr;
            cap_addr = mem_addr;
            @(posedge clk);
            #1;
            for (int i = L-1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
            pv[0] = cap_rd;
            pd[0] = memfn(cap_addr);
            mem_valid = pv[L-1];
            mem_rdata = pv[L-1] ? pd[L-1] : 16'($urandom);
            if (allow_stray && !m_act && !pv[L-1] && $urandom_range(0, 1) == 0)
                mem_valid = 1'b1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    bit i_pend = 0, d_pend = 0, i_drop = 0, d_drop = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        i_drop = 0;
        d_drop = 0;
        if (m_i_done_prev) begin i_req = 0; i_pend = 0; i_drop = 1; end
        if (m_d_done_prev) begin d_req = 0; d_pend = 0; d_drop = 1; end
    endtask

    task automatic chk_neg();
        bit          f, w, e_en, e_wr, e_ifw, e_dfw;
        int          r;
        logic [15:0] e_addr, e_wd;
        @(negedge clk);
        f      = rst_n && m_act && !m_wr;
        w      = rst_n && m_act &&  m_wr;
        r      = m_r;
        e_en   = (f && r >= 1 && r <= BW) || (w && r == 1);
        e_wr   = w && r == 1;
        e_addr = !e_en ? 16'h0 : w ? m_waddr : m_base + 16'(2*(r-1));
        e_wd   = e_wr ? m_wdata : 16'h0;
        e_ifw  = f && r >= L+1 && r <= BW+L && !m_d;
        e_dfw  = f && r >= L+1 && r <= BW+L &&  m_d;
        chk("mem_en",    16'(mem_en),    16'(e_en));
        chk("mem_wr",    16'(mem_wr),    16'(e_wr));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      e_wd);
        chk("i_fill_we", 16'(i_fill_we), 16'(e_ifw));
        chk("d_fill_we", 16'(d_fill_we), 16'(e_dfw));
        chk("i_done",    16'(i_done),    16'(rst_n && m_act && r == done_r(m_wr) && !m_d));
        chk("d_done",    16'(d_done),    16'(rst_n && m_act && r == done_r(m_wr) &&  m_d));
        chk("busy",      16'(busy),      16'(rst_n && m_act));
        if (e_ifw || e_dfw) begin
            chk("fill_word", 16'(fill_word), 16'(r-L-1));
            chk("fill_data", fill_data, memfn(m_base + 16'(2*(r-L-1))));
        end
        if (!rst_n) chk("rst_fill_word", 16'(fill_word), 16'h0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin nxt(); chk_neg(); end
    endtask

    int late_fwe, late_vld;

    initial begin
        idle(3);
        chk("reset_busy", 16'(busy), 16'h0);
        nxt(); rst_n = 1'b1; chk_neg();
        idle(3);

        // Instruction fill at 0x1234
        nxt(); i_req = 1; i_addr = 16'h1234; i_pend = 1; chk_neg();
        for (int k = 1; k <= 14; k++) begin
            nxt(); chk_neg();
            case (k)
                1:  chk("if_addr_first", mem_addr, 16'h1230);
                5:  chk("if_first_we",   {i_fill_we, 12'h0, 3'(fill_word)}, 16'h8000);
                8:  chk("if_addr_last",  mem_addr, 16'h123E);
                9:  chk("if_en_off",     16'(mem_en), 16'h0);
                12: chk("if_last_we",    {i_fill_we, 12'h0, 3'(fill_word)}, 16'h8007);
                13: chk("if_done",       16'(i_done), 16'h1);
                14: chk("if_idle",       16'(busy), 16'h0);
                default: ;
            endcase
        end
        idle(2);

        // Store 0xBEEF to 0x0040
        nxt(); d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF; d_pend = 1; chk_neg();
        for (int k = 1; k <= 3; k++) begin
            nxt(); chk_neg();
            case (k)
                1: chk("st_issue", {mem_en, mem_wr, 14'h0}, 16'hC000);
                2: chk("st_done",  16'(d_done), 16'h1);
                3: chk("st_idle",  16'(busy),   16'h0);
                default: ;
            endcase
            if (k == 1) begin
                chk("st_addr",  mem_addr,  16'h0040);
                chk("st_wdata", mem_wdata, 16'hBEEF);
            end
        end
        idle(2);

        // Simultaneous I fill and D fill: data side first
        nxt(); i_req = 1; i_addr = 16'h0100; i_pend = 1;
        d_req = 1; d_wr = 0; d_addr = 16'h2000; d_pend = 1; chk_neg();
        for (int k = 1; k <= 28; k++) begin
            nxt(); chk_neg();
            case (k)
                1:  chk("tie_d_first", mem_addr, 16'h2000);
                13: chk("tie_d_done",  16'(d_done), 16'h1);
                15: chk("tie_i_issue", mem_addr, 16'h0100);
                27: chk("tie_i_done",  16'(i_done), 16'h1);
                default: ;
            endcase
        end
        idle(2);

        // i_req dropped mid-fill: fill still completes
        nxt(); i_req = 1; i_addr = 16'h0500; i_pend = 1; chk_neg();
        for (int k = 1; k <= 14; k++) begin
            nxt();
            if (k == 3) begin i_req = 0; i_pend = 0; end
            chk_neg();
            if (k == 8)  chk("drop_addr_last", mem_addr, 16'h050E);
            if (k == 13) chk("drop_done", 16'(i_done), 16'h1);
        end
        idle(2);

        // Reset in cycle 4 of a fill; late returns must be ignored
        late_fwe = 0;
        late_vld = 0;
        nxt(); i_req = 1; i_addr = 16'h0700; i_pend = 1; chk_neg();
        for (int k = 1; k <= 16; k++) begin
            nxt();
            if (k == 4) begin rst_n = 0; i_req = 0; i_pend = 0; end
            if (k == 6) begin rst_n = 1; allow_stray = 1; end
            chk_neg();
            if (k == 4) chk("rst_outs", {mem_en, mem_wr, busy, i_fill_we, i_done, 11'h0}, 16'h0);
            if (k == 4) chk("rst_addr", mem_addr, 16'h0);
            if (k >= 6) begin
                late_fwe += int'(i_fill_we) + int'(d_fill_we);
                late_vld += int'(mem_valid);
            end
        end
        chk("late_fill_we", 16'(late_fwe), 16'h0);
        chk("late_valid_seen", 16'(late_vld >= 2), 16'h1);
        chk("post_rst_busy", 16'(busy), 16'h0);
        idle(4);

        // Random traffic with stray mem_valid pulses in idle cycles
        for (int c = 0; c < 2000; c++) begin
            nxt();
            if (!i_pend && !i_drop && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_addr = 16'($urandom); i_pend = 1;
            end
            if (!d_pend && !d_drop && $urandom_range(0, 3) == 0) begin
                d_req = 1; d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom); d_wdata = 16'($urandom); d_pend = 1;
            end
            chk_neg();
        end
        idle(40);
        chk("drain_idle", 16'(busy), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
